// File: rtl/dma_bus_defs.sv
// Shared DMA bus definitions: arbiter state encodings, requester indices and
// the packed request bundle muxed onto the system bus.
package dma_bus_defs;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_OWN   = 2'd1;
  localparam logic [1:0] S_GAP   = 2'd2;
  localparam logic [1:0] S_ABORT = 2'd3;

  localparam logic [1:0] REQ_CTRL = 2'd0;
  localparam logic [1:0] REQ_RD   = 2'd1;
  localparam logic [1:0] REQ_WR   = 2'd2;

  localparam int NREQ = 3;

  typedef struct packed {
    logic        cyc;
    logic        stb;
    logic        we;
    logic        cab;
    logic [3:0]  sel;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [31:0] dat64;
  } wb_req_t;

  function automatic logic [1:0] oh_to_idx(input logic [2:0] oh);
    if (oh[2])      return REQ_WR;
    else if (oh[1]) return REQ_RD;
    else            return REQ_CTRL;
  endfunction

endpackage

// File: rtl/rr_pick3.sv
// Combinational 3-way round-robin selector: first requester after `last_i`
// (wrapping), returned one-hot; zero when nobody requests.
module rr_pick3 (
  input  logic [2:0] req_i,
  input  logic [1:0] last_i,
  output logic [2:0] gnt_o
);

  always_comb begin
    gnt_o = 3'b000;
    case (last_i)
      2'd0: begin
        if (req_i[1])      gnt_o = 3'b010;
        else if (req_i[2]) gnt_o = 3'b100;
        else if (req_i[0]) gnt_o = 3'b001;
      end
      2'd1: begin
        if (req_i[2])      gnt_o = 3'b100;
        else if (req_i[0]) gnt_o = 3'b001;
        else if (req_i[1]) gnt_o = 3'b010;
      end
      default: begin
        if (req_i[0])      gnt_o = 3'b001;
        else if (req_i[1]) gnt_o = 3'b010;
        else if (req_i[2]) gnt_o = 3'b100;
      end
    endcase
  end

endmodule

// File: rtl/wb_mst_arb.sv
// Three-requester Wishbone master arbiter: round-robin grant held for a whole
// cycle, grant-gated termination routing, and a stalled-strobe watchdog.
module wb_mst_arb
  import dma_bus_defs::*;
#(
  parameter int TIMEOUT = 1000,
  parameter int TO_W    = 10
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_n,
  input  logic        m0_cyc, m0_stb, m0_we, m0_cab,
  input  logic [3:0]  m0_sel,
  input  logic [31:0] m0_adr, m0_dat, m0_dat64,
  output logic [31:0] m0_rdat, m0_rdat64,
  output logic        m0_ack, m0_err, m0_rty,
  input  logic        m1_cyc, m1_stb, m1_we, m1_cab,
  input  logic [3:0]  m1_sel,
  input  logic [31:0] m1_adr, m1_dat, m1_dat64,
  output logic [31:0] m1_rdat, m1_rdat64,
  output logic        m1_ack, m1_err, m1_rty,
  input  logic        m2_cyc, m2_stb, m2_we, m2_cab,
  input  logic [3:0]  m2_sel,
  input  logic [31:0] m2_adr, m2_dat, m2_dat64,
  output logic [31:0] m2_rdat, m2_rdat64,
  output logic        m2_ack, m2_err, m2_rty,
  output logic        wbs_cyc4, wbs_stb4, wbs_we4, wbs_cab4,
  output logic [3:0]  wbs_sel4,
  output logic [31:0] wbs_adr4,
  output logic [31:0] wbs_dat_i4, wbs_dat64_i4,
  input  logic [31:0] wbs_dat_o4, wbs_dat64_o4,
  input  logic        wbs_ack4, wbs_err4, wbs_rty4,
  output logic [2:0]  gnt,
  output logic [1:0]  arb_state
);

  localparam logic [TO_W-1:0] TO_LAST = (TIMEOUT > 0) ? TO_W'(TIMEOUT - 1) : '0;

  logic [1:0]      state_q, state_d;
  logic [2:0]      gnt_q, gnt_d, pick;
  logic [1:0]      last_q, last_d;
  logic [TO_W-1:0] wd_q, wd_d;

  wb_req_t req_a  [NREQ];
  wb_req_t masked [NREQ];
  wb_req_t sel_req;
  logic [2:0] cyc_v, ack_v, err_v, rty_v;
  logic own, term, wd_fire;

  assign req_a[0] = {m0_cyc, m0_stb, m0_we, m0_cab, m0_sel, m0_adr, m0_dat, m0_dat64};
  assign req_a[1] = {m1_cyc, m1_stb, m1_we, m1_cab, m1_sel, m1_adr, m1_dat, m1_dat64};
  assign req_a[2] = {m2_cyc, m2_stb, m2_we, m2_cab, m2_sel, m2_adr, m2_dat, m2_dat64};
  assign cyc_v    = {m2_cyc, m1_cyc, m0_cyc};

  rr_pick3 u_pick (
    .req_i  (cyc_v),
    .last_i (last_q),
    .gnt_o  (pick)
  );

  // AND-OR mux keyed only on the registered grant, so the bus is stable within a grant
  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_req
      assign masked[gi] = gnt_q[gi] ? req_a[gi] : '0;
      assign ack_v[gi]  = gnt_q[gi] & own & ~wd_fire & wbs_ack4;
      assign rty_v[gi]  = gnt_q[gi] & own & ~wd_fire & wbs_rty4;
      assign err_v[gi]  = gnt_q[gi] & own & (wd_fire | wbs_err4);
    end
  endgenerate

  assign sel_req = masked[0] | masked[1] | masked[2];
  assign own     = (state_q == S_OWN);
  assign term    = wbs_ack4 | wbs_err4 | wbs_rty4;

  // A firing watchdog ignores any same-cycle termination: the timeout wins
  assign wd_fire = (TIMEOUT != 0) && own && sel_req.cyc && sel_req.stb && (wd_q == TO_LAST);

  assign wbs_cyc4     = own & sel_req.cyc;
  assign wbs_stb4     = own & sel_req.stb;
  assign wbs_we4      = sel_req.we;
  assign wbs_cab4     = sel_req.cab;
  assign wbs_sel4     = sel_req.sel;
  assign wbs_adr4     = sel_req.adr;
  assign wbs_dat_i4   = sel_req.dat;
  assign wbs_dat64_i4 = sel_req.dat64;

  assign {m0_rdat, m1_rdat, m2_rdat}       = {3{wbs_dat_o4}};
  assign {m0_rdat64, m1_rdat64, m2_rdat64} = {3{wbs_dat64_o4}};
  assign {m2_ack, m1_ack, m0_ack} = ack_v;
  assign {m2_err, m1_err, m0_err} = err_v;
  assign {m2_rty, m1_rty, m0_rty} = rty_v;
  assign gnt       = gnt_q;
  assign arb_state = state_q;

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    case (state_q)
      S_IDLE: begin
        if (|cyc_v) begin
          gnt_d   = pick;
          last_d  = oh_to_idx(pick);
          state_d = S_OWN;
        end
      end
      S_OWN: begin
        if (!sel_req.cyc) begin
          gnt_d   = 3'b000;
          state_d = S_GAP;
        end else if (wd_fire) begin
          state_d = S_ABORT;
        end
      end
      S_GAP: state_d = S_IDLE;
      default: begin
        if (!sel_req.cyc) begin
          gnt_d   = 3'b000;
          state_d = S_GAP;
        end
      end
    endcase
  end

  always_comb begin
    if (state_q == S_IDLE || !wbs_stb4 || term || wd_fire) wd_d = '0;
    else                                                    wd_d = wd_q + 1'b1;
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      state_q <= S_IDLE;
      gnt_q   <= 3'b000;
      last_q  <= REQ_WR;
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
      wd_q    <= wd_d;
    end
  end

endmodule

// File: tb/tb_wb_mst_arb.sv
// Directed bench for wb_mst_arb: single burst, contention, fairness, timeout,
// retry and asynchronous reset mid-burst.
module tb_wb_mst_arb;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [2:0]  m_cyc, m_stb, m_we, m_cab;
  logic [3:0]  m_sel   [3];
  logic [31:0] m_adr   [3];
  logic [31:0] m_dat   [3];
  logic [31:0] m_dat64 [3];
  wire  [31:0] m_rdat  [3];
  wire  [31:0] m_rdat64[3];
  wire  [2:0]  m_ack, m_err, m_rty;

  wire         wbs_cyc4, wbs_stb4, wbs_we4, wbs_cab4;
  wire  [3:0]  wbs_sel4;
  wire  [31:0] wbs_adr4, wbs_dat_i4, wbs_dat64_i4;
  logic [31:0] wbs_dat_o4, wbs_dat64_o4;
  logic        wbs_ack4, wbs_err4, wbs_rty4;
  wire  [2:0]  gnt;
  wire  [1:0]  arb_state;

  int total = 0;
  int bad   = 0;

  wb_mst_arb #(.TIMEOUT(8), .TO_W(10)) dut (
    .wb_clk_i(clk), .wb_rst_n(rst_n),
    .m0_cyc(m_cyc[0]), .m0_stb(m_stb[0]), .m0_we(m_we[0]), .m0_cab(m_cab[0]),
    .m0_sel(m_sel[0]), .m0_adr(m_adr[0]), .m0_dat(m_dat[0]), .m0_dat64(m_dat64[0]),
    .m0_rdat(m_rdat[0]), .m0_rdat64(m_rdat64[0]),
    .m0_ack(m_ack[0]), .m0_err(m_err[0]), .m0_rty(m_rty[0]),
    .m1_cyc(m_cyc[1]), .m1_stb(m_stb[1]), .m1_we(m_we[1]), .m1_cab(m_cab[1]),
    .m1_sel(m_sel[1]), .m1_adr(m_adr[1]), .m1_dat(m_dat[1]), .m1_dat64(m_dat64[1]),
    .m1_rdat(m_rdat[1]), .m1_rdat64(m_rdat64[1]),
    .m1_ack(m_ack[1]), .m1_err(m_err[1]), .m1_rty(m_rty[1]),
    .m2_cyc(m_cyc[2]), .m2_stb(m_stb[2]), .m2_we(m_we[2]), .m2_cab(m_cab[2]),
    .m2_sel(m_sel[2]), .m2_adr(m_adr[2]), .m2_dat(m_dat[2]), .m2_dat64(m_dat64[2]),
    .m2_rdat(m_rdat[2]), .m2_rdat64(m_rdat64[2]),
    .m2_ack(m_ack[2]), .m2_err(m_err[2]), .m2_rty(m_rty[2]),
    .wbs_cyc4(wbs_cyc4), .wbs_stb4(wbs_stb4), .wbs_we4(wbs_we4), .wbs_cab4(wbs_cab4),
    .wbs_sel4(wbs_sel4), .wbs_adr4(wbs_adr4),
    .wbs_dat_i4(wbs_dat_i4), .wbs_dat64_i4(wbs_dat64_i4),
    .wbs_dat_o4(wbs_dat_o4), .wbs_dat64_o4(wbs_dat64_o4),
    .wbs_ack4(wbs_ack4), .wbs_err4(wbs_err4), .wbs_rty4(wbs_rty4),
    .gnt(gnt), .arb_state(arb_state)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Entered in an IDLE cycle with requests driven; returns in the following GAP cycle.
  task automatic run_grant(input int idx);
    tick();
    chk($sformatf("grant%0d_state", idx), arb_state, 64'd1);
    chk($sformatf("grant%0d_gnt", idx), gnt, 64'd1 << idx);
    chk($sformatf("grant%0d_adr", idx), wbs_adr4, 64'(32'h1000 * (idx + 1)));
    tick();
    tick();
    m_cyc[idx] = 1'b0;
    m_stb[idx] = 1'b0;
    tick();
    chk($sformatf("grant%0d_gap_state", idx), arb_state, 64'd2);
    chk($sformatf("grant%0d_gap_gnt", idx), gnt, 64'd0);
    $display("grant to m%0d done at %0t", idx, $time);
  endtask

  initial begin
    #200000;
    $display("FAIL global_time_limit: observed=running expected=finished");
    $fatal(1, "time limit");
  end

  initial begin
    rst_n = 1'b0;
    m_cyc = '0; m_stb = '0; m_we = '0; m_cab = '0;
    wbs_dat_o4 = '0; wbs_dat64_o4 = '0;
    wbs_ack4 = 1'b0; wbs_err4 = 1'b0; wbs_rty4 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      m_sel[i]   = 4'hF;
      m_adr[i]   = 32'h1000 * (i + 1);
      m_dat[i]   = 32'hA000_0000 + i;
      m_dat64[i] = 32'hB000_0000 + i;
    end
    repeat (2) tick();
    chk("rst_gnt", gnt, 64'd0);
    chk("rst_state", arb_state, 64'd0);
    chk("rst_wbs_cyc", wbs_cyc4, 64'd0);
    chk("rst_wbs_adr", wbs_adr4, 64'd0);
    chk("rst_term", {m_ack, m_err, m_rty}, 64'd0);
    rst_n = 1'b1;
    tick();

    // Single 4-beat burst read from m0
    m_cyc[0] = 1'b1; m_stb[0] = 1'b1; m_cab[0] = 1'b1;
    #1;
    chk("t1_cyc_before_grant", wbs_cyc4, 64'd0);
    tick();
    chk("t1_state", arb_state, 64'd1);
    chk("t1_gnt", gnt, 64'b001);
    chk("t1_wbs_cyc", wbs_cyc4, 64'd1);
    chk("t1_wbs_adr", wbs_adr4, 64'h1000);
    chk("t1_wbs_cab", wbs_cab4, 64'd1);
    chk("t1_wbs_dat64", wbs_dat64_i4, 64'hB000_0000);
    for (int b = 0; b < 4; b++) begin
      wbs_dat_o4 = 32'hD000_0000 + b;
      wbs_ack4   = 1'b1;
      #1;
      chk($sformatf("t1_ack_b%0d", b), m_ack[0], 64'd1);
      chk($sformatf("t1_rdat_b%0d", b), m_rdat[0], 64'(32'hD000_0000 + b));
      chk($sformatf("t1_other_ack_b%0d", b), m_ack[2:1], 64'd0);
      $display("t1 beat %0d rdat=%0h", b, m_rdat[0]);
      tick();
    end
    wbs_ack4 = 1'b0;
    m_cyc[0] = 1'b0; m_stb[0] = 1'b0; m_cab[0] = 1'b0;
    #1;
    chk("t1_drop_state", arb_state, 64'd1);
    chk("t1_drop_wbs_cyc", wbs_cyc4, 64'd0);
    tick();
    chk("t1_gap", arb_state, 64'd2);
    chk("t1_gap_gnt", gnt, 64'd0);
    tick();
    chk("t1_idle", arb_state, 64'd0);

    // Contention from a fresh reset: order 0,1,2 with one GAP between
    rst_n = 1'b0; tick(); rst_n = 1'b1; tick();
    m_cyc = 3'b111; m_stb = 3'b111;
    run_grant(0);
    tick();
    chk("t2_idle_between", arb_state, 64'd0);
    run_grant(1);
    tick();
    run_grant(2);

    // Fairness: m1 always requesting, m0/m2 alternate
    m_cyc = 3'b011; m_stb = 3'b011;
    tick();
    run_grant(0);
    m_cyc[2] = 1'b1; m_stb[2] = 1'b1; tick();
    run_grant(1);
    m_cyc[1] = 1'b1; m_stb[1] = 1'b1; tick();
    run_grant(2);
    m_cyc[0] = 1'b1; m_stb[0] = 1'b1; tick();
    run_grant(0);
    m_cyc[2] = 1'b1; m_stb[2] = 1'b1; tick();
    run_grant(1);
    m_cyc = '0; m_stb = '0;
    tick();
    tick();
    chk("t3_idle", arb_state, 64'd0);
    chk("t3_idle_gnt", gnt, 64'd0);

    // Watchdog: slave never acks, abort on the 8th stalled cycle
    m_cyc[0] = 1'b1; m_stb[0] = 1'b1;
    tick();
    chk("t4_gnt", gnt, 64'b001);
    for (int k = 1; k < 8; k++) begin
      chk($sformatf("t4_no_err_c%0d", k), m_err[0], 64'd0);
      tick();
    end
    wbs_ack4 = 1'b1;
    #1;
    chk("t4_err_pulse", m_err[0], 64'd1);
    chk("t4_ack_suppressed", m_ack[0], 64'd0);
    $display("t4 watchdog fired at %0t", $time);
    tick();
    chk("t4_abort_state", arb_state, 64'd3);
    chk("t4_abort_wbs_cyc", wbs_cyc4, 64'd0);
    chk("t4_err_one_cycle", m_err[0], 64'd0);
    chk("t4_abort_no_ack", m_ack[0], 64'd0);
    wbs_ack4 = 1'b0;
    tick();
    chk("t4_abort_hold", arb_state, 64'd3);
    m_cyc[0] = 1'b0; m_stb[0] = 1'b0;
    tick();
    chk("t4_gap", arb_state, 64'd2);
    tick();

    // Retry: two rty then ack, grant stays with m1
    m_cyc[1] = 1'b1; m_stb[1] = 1'b1;
    tick();
    chk("t5_gnt", gnt, 64'b010);
    wbs_rty4 = 1'b1;
    #1;
    chk("t5_rty1", m_rty[1], 64'd1);
    chk("t5_rty_other", m_rty[0], 64'd0);
    tick();
    chk("t5_rty2", m_rty[1], 64'd1);
    chk("t5_gnt_hold", gnt, 64'b010);
    wbs_rty4 = 1'b0; wbs_ack4 = 1'b1;
    #1;
    chk("t5_ack", m_ack[1], 64'd1);
    chk("t5_ack_no_rty", m_rty[1], 64'd0);
    chk("t5_gnt_final", gnt, 64'b010);
    $display("t5 retry sequence complete at %0t", $time);
    tick();
    wbs_ack4 = 1'b0;
    m_cyc[1] = 1'b0; m_stb[1] = 1'b0;
    tick();
    chk("t5_gap", arb_state, 64'd2);
    tick();

    // Asynchronous reset during beat 2 of an m0 burst
    m_cyc[0] = 1'b1; m_stb[0] = 1'b1; m_cab[0] = 1'b1;
    tick();
    chk("t6_gnt", gnt, 64'b001);
    wbs_ack4 = 1'b1;
    tick();
    rst_n = 1'b0;
    #1;
    chk("t6_rst_wbs_cyc", wbs_cyc4, 64'd0);
    chk("t6_rst_gnt", gnt, 64'd0);
    chk("t6_rst_term", {m_ack, m_err, m_rty}, 64'd0);
    chk("t6_rst_state", arb_state, 64'd0);
    wbs_ack4 = 1'b0;
    tick();
    rst_n = 1'b1;
    m_cyc[2] = 1'b1; m_stb[2] = 1'b1;
    tick();
    chk("t6_post_rst_gnt", gnt, 64'b001);
    chk("t6_post_rst_adr", wbs_adr4, 64'h1000);
    $display("t6 reset recovery grant=%b at %0t", gnt, $time);
    m_cyc = '0; m_stb = '0; m_cab = '0;
    repeat (3) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
